// File: rtl/ex_div_pkg.sv
// Shared constants and helpers for the EX-stage divider.
// Optional feature macro: DIV_ZERO_FLAG_EN (adds the divzero_o flag).
package ex_div_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    // FSM state encodings (legacy define.v values)
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand; only negative values in signed mode are negated
    function automatic logic [RegBus-1:0] abs_op(input logic is_signed, input logic [RegBus-1:0] v);
        return (is_signed && v[RegBus-1]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider start/ready handshake bundle.
// Optional feature macro: DIV_ZERO_FLAG_EN (adds divzero_o).
interface ex_div_if;
    import ex_div_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                    divzero_o;
`endif

    // EX stage side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
        input  divzero_o,
`endif
        input  result_o, ready_o
    );

    // Divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
        output divzero_o,
`endif
        output result_o, ready_o
    );

endinterface

// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider (1 quotient bit per cycle) for the EX stage.
// Returns {remainder, quotient} for DIV (signed) and DIVU (unsigned).
// Optional feature macro: DIV_ZERO_FLAG_EN (drives divzero_o on a zero divisor).
module ex_div
    import ex_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  ex
);

    logic [1:0]              state_q,    state_d;
    logic [5:0]              cnt_q,      cnt_d;
    logic [64:0]             dividend_q, dividend_d;
    logic [RegBus-1:0]       divisor_q,  divisor_d;
    logic                    op1_neg_q,  op1_neg_d;
    logic                    op2_neg_q,  op2_neg_d;
    logic [DoubleRegBus-1:0] result_q,   result_d;
    logic                    ready_q,    ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                    divzero_q,  divzero_d;
`endif

    logic [32:0]             diff;
    logic [RegBus-1:0]       quot;
    logic [RegBus-1:0]       rem;

    // Next-state, trial subtract and result sign fix-up
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op1_neg_d  = op1_neg_q;
        op2_neg_d  = op2_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
        divzero_d  = divzero_q;
`endif
        diff = dividend_q[64:32] - {1'b0, divisor_q};
        quot = dividend_q[31:0];
        rem  = dividend_q[64:33];

        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (ex.start_i == DivStart && !ex.annul_i) begin
                    if (ex.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        op1_neg_d  = ex.signed_div_i & ex.opdata1_i[RegBus-1];
                        op2_neg_d  = ex.signed_div_i & ex.opdata2_i[RegBus-1];
                        divisor_d  = abs_op(ex.signed_div_i, ex.opdata2_i);
                        dividend_d = {32'b0, abs_op(ex.signed_div_i, ex.opdata1_i), 1'b0};
                    end
                end
            end
            DivByZero: begin
                state_d    = DivEnd;
                dividend_d = '0;
                result_d   = '0;
                ready_d    = DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
                divzero_d  = 1'b1;
`endif
            end
            DivOn: begin
                if (ex.annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (cnt_q != 6'd32) begin
                    // Partial remainder sits in [64:33]; quotient bits enter at [0]
                    if (diff[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    if (op1_neg_q ^ op2_neg_q) begin
                        quot = neg32(dividend_q[31:0]);
                    end
                    if (op1_neg_q) begin
                        rem = neg32(dividend_q[64:33]);
                    end
                    result_d = {rem, quot};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end
            default: begin // DivEnd
                if (ex.start_i == DivStop) begin
                    state_d   = DivFree;
                    ready_d   = DivResultNotReady;
                    result_d  = '0;
`ifdef DIV_ZERO_FLAG_EN
                    divzero_d = 1'b0;
`endif
                end
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            divzero_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op1_neg_q  <= op1_neg_d;
            op2_neg_q  <= op2_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            divzero_q  <= divzero_d;
`endif
        end
    end

    assign ex.result_o = result_q;
    assign ex.ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign ex.divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random DIV/DIVU
// against an arithmetic reference model.
module tb_ex_div;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_div_if bus ();

    ex_div u_dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: divide magnitudes, then apply sign rules
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub;
        logic [31:0] q, r;
        bit na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ua = na ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        ub = nb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        q  = 32'(ua / ub);
        r  = 32'(ua % ub);
        if (na != nb) q = 32'd0 - q;
        if (na)       r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Edges counted from the accepting edge E0 inclusive; operands scrambled while busy
    task automatic wait_ready(output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
            if (bus.ready_o === 1'b1) begin
                done = 1'b1;
            end else begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom);
            end
        end
    endtask

    task automatic release_and_check(input string tag);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, " ready_drop"}, 64'(bus.ready_o), 64'd0);
        check({tag, " result_clear"}, bus.result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " divzero_clear"}, 64'(bus.divzero_o), 64'd0);
`endif
    endtask

    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int n;
        start_op(sgn, a, b);
        wait_ready(n);
        check({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, " result"}, bus.result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " divzero"}, 64'(bus.divzero_o), (b == 32'd0) ? 64'd1 : 64'd0);
`endif
        release_and_check(tag);
    endtask

    initial begin
        int n;
        bit seen;
        bit sgn;
        logic [31:0] a, b;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #1;
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_div("divu_7_2",      1'b0, 32'd7,          32'd2,          64'h00000001_00000003);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD);
        run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD);
        run_div("divu_5_0",      1'b0, 32'd5,          32'd0,          64'd0);
        run_div("div_overflow",  1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF);

        // Annul at iteration 10, keep start/annul asserted: nothing may complete
        start_op(1'b0, 32'd1000, 32'd7);
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul ready", 64'(bus.ready_o), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("annul no_ready", 64'(seen), 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Reset at iteration 20
        start_op(1'b0, 32'd12345, 32'd11);
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset while a result is held must clear outputs without a clock edge
        start_op(1'b1, 32'hFFFFFF00, 32'd3);
        wait_ready(n);
        check("rst_end pre result", bus.result_o, model(1'b1, 32'hFFFFFF00, 32'd3));
        #2 rst = 1'b0;
        #1;
        check("rst_end ready", 64'(bus.ready_o), 64'd0);
        check("rst_end result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Hold start 5 cycles past ready
        start_op(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_ready(n);
        check("hold latency", 64'(n), 64'd34);
        repeat (5) begin
            @(negedge clk);
            check("hold ready", 64'(bus.ready_o), 64'd1);
            check("hold result", bus.result_o, 64'hFFFFFFFE_FFFFFFF2);
        end
        release_and_check("hold");

        // Random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom % 4)
                0: b = $urandom;
                1: b = $urandom % 16;
                2: b = 32'd0 - (($urandom % 16) + 32'd1);
                default: begin
                    a = 32'h80000000;
                    b = $urandom;
                end
            endcase
            run_div($sformatf("rand%0d s=%0d %h/%h", i, sgn, a, b), sgn, a, b, model(sgn, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
